// File: rtl/rbcp_reg_responder.sv
// RBCP target: decodes SiTCP register-bus strobes into RW control bytes and RO status bytes,
// answering every mapped access with a single-cycle RBCP_ACK after an optional wait.
module rbcp_reg_responder #(
    parameter logic [31:0]         BASE_ADDR   = 32'h0000_0000,
    parameter int                  NUM_RW      = 16,
    parameter int                  NUM_RO      = 8,
    parameter int                  WAIT_CYCLES = 0,
    parameter logic [8*NUM_RW-1:0] REG_INIT    = '0
) (
    input  logic                                  CLK,
    input  logic                                  RSTn,
    input  logic                                  RBCP_ACT,
    input  logic [31:0]                           RBCP_ADDR,
    input  logic                                  RBCP_WE,
    input  logic [7:0]                            RBCP_WD,
    input  logic                                  RBCP_RE,
    output logic                                  RBCP_ACK,
    output logic [7:0]                            RBCP_RD,
    input  logic [((NUM_RO > 0) ? 8*NUM_RO : 8)-1:0] STATUS_IN,
    output logic [8*NUM_RW-1:0]                   REG_OUT,
    output logic [NUM_RW-1:0]                     REG_WSTB,
    output logic                                  MISS,
    output logic [1:0]                            dbg_state
);

    localparam logic [31:0] NUM_MAP = 32'(NUM_RW + NUM_RO);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          off_q, off_d;
    logic                rd_op_q, rd_op_d;
    logic                ack_q, ack_d;
    logic [7:0]          rd_q, rd_d;
    logic                miss_q, miss_d;
    logic [NUM_RW-1:0]   wstb_q, wstb_d;
    logic [8*NUM_RW-1:0] regs_q, regs_d;

    logic [31:0] off_full;
    logic        strobe;
    logic        hit;
    logic        enter_ack;
    logic [7:0]  sel_off;
    logic [7:0]  rd_mux;

    always_comb begin
        off_full  = RBCP_ADDR - BASE_ADDR;
        strobe    = RBCP_ACT && (RBCP_WE || RBCP_RE);
        hit       = off_full < NUM_MAP;
        state_d   = state_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        rd_op_d   = rd_op_q;
        ack_d     = 1'b0;
        rd_d      = 8'h00;
        miss_d    = 1'b0;
        wstb_d    = '0;
        regs_d    = regs_q;
        enter_ack = 1'b0;
        sel_off   = off_q;
        rd_mux    = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    if (!hit) begin
                        miss_d = 1'b1;
                    end else begin
                        off_d   = off_full[7:0];
                        sel_off = off_full[7:0];
                        // A simultaneous WE wins; the RE is dropped.
                        rd_op_d = !RBCP_WE;
                        for (int i = 0; i < NUM_RW; i++) begin
                            if (RBCP_WE && off_full == 32'(i)) begin
                                regs_d[8*i +: 8] = RBCP_WD;
                                wstb_d[i]        = 1'b1;
                            end
                        end
                        if (WAIT_CYCLES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = 4'(WAIT_CYCLES);
                        end else begin
                            enter_ack = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!RBCP_ACT) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < NUM_RW; i++) begin
            if (sel_off == 8'(i)) rd_mux = regs_q[8*i +: 8];
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (sel_off == 8'(NUM_RW + j)) rd_mux = STATUS_IN[8*j +: 8];
        end

        // Read data is captured on the same edge that enters ACK.
        if (enter_ack) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            rd_d    = rd_op_d ? rd_mux : 8'h00;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            rd_op_q <= 1'b0;
            ack_q   <= 1'b0;
            rd_q    <= '0;
            miss_q  <= 1'b0;
            wstb_q  <= '0;
            regs_q  <= REG_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            rd_op_q <= rd_op_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            miss_q  <= miss_d;
            wstb_q  <= wstb_d;
            regs_q  <= regs_d;
        end
    end

    assign RBCP_ACK  = ack_q;
    assign RBCP_RD   = rd_q;
    assign REG_OUT   = regs_q;
    assign REG_WSTB  = wstb_q;
    assign MISS      = miss_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Bench for rbcp_reg_responder: instance 0 has no wait, instance 1 waits 3 cycles; both
// share BASE 0x100, 16 RW bytes resetting to A5 and 8 status bytes 7C..83.
module tb_rbcp_reg_responder;

    localparam logic [31:0] BASE = 32'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         act[2], we[2], re[2];
    logic [31:0]  addr[2];
    logic [7:0]   wd[2];
    logic         ack[2], miss[2];
    logic [7:0]   rd[2];
    logic [127:0] reg_out[2];
    logic [15:0]  wstb[2];
    logic [1:0]   dbg[2];
    logic [63:0]  status;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mdl[2][16];

    rbcp_reg_responder #(.BASE_ADDR(BASE), .NUM_RW(16), .NUM_RO(8), .WAIT_CYCLES(0),
                         .REG_INIT({16{8'hA5}})) dut0 (
        .CLK(clk), .RSTn(rst_n), .RBCP_ACT(act[0]), .RBCP_ADDR(addr[0]), .RBCP_WE(we[0]),
        .RBCP_WD(wd[0]), .RBCP_RE(re[0]), .RBCP_ACK(ack[0]), .RBCP_RD(rd[0]),
        .STATUS_IN(status), .REG_OUT(reg_out[0]), .REG_WSTB(wstb[0]), .MISS(miss[0]),
        .dbg_state(dbg[0]));

    rbcp_reg_responder #(.BASE_ADDR(BASE), .NUM_RW(16), .NUM_RO(8), .WAIT_CYCLES(3),
                         .REG_INIT({16{8'hA5}})) dut1 (
        .CLK(clk), .RSTn(rst_n), .RBCP_ACT(act[1]), .RBCP_ADDR(addr[1]), .RBCP_WE(we[1]),
        .RBCP_WD(wd[1]), .RBCP_RE(re[1]), .RBCP_ACK(ack[1]), .RBCP_RD(rd[1]),
        .STATUS_IN(status), .REG_OUT(reg_out[1]), .REG_WSTB(wstb[1]), .MISS(miss[1]),
        .dbg_state(dbg[1]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mdl_vec(input int d);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = mdl[d][i];
        return v;
    endfunction

    task automatic mdl_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) mdl[d][i] = 8'hA5;
    endtask

    // Present one strobe for a single cycle; returns 1 ns into the following cycle.
    task automatic strobe(input int d, input bit w, input bit r, input logic [31:0] a,
                          input logic [7:0] v);
        we[d] = w; re[d] = r; addr[d] = a; wd[d] = v;
        tick();
        we[d] = 1'b0; re[d] = 1'b0;
    endtask

    task automatic count_acks(input int d, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cnt += int'(ack[d]);
            tick();
        end
    endtask

    // One full transaction with expected latency 1+WAIT and model-derived data.
    task automatic do_txn(input int d, input bit w, input bit r, input logic [31:0] a,
                          input logic [7:0] v);
        logic [31:0] off;
        int          o, lat, n;
        bit          hit;
        logic [15:0] exp_wstb;
        off      = a - BASE;
        o        = int'(off);
        lat      = (d == 0) ? 1 : 4;
        hit      = off < 32'd24;
        exp_wstb = '0;
        if (hit) begin
            if (w) exp_q.push_back(8'h00);
            else   exp_q.push_back((o < 16) ? mdl[d][o] : status[8*(o-16) +: 8]);
            if (w && o < 16) begin
                mdl[d][o]   = v;
                exp_wstb[o] = 1'b1;
            end
        end
        strobe(d, w, r, a, v);
        check($sformatf("miss%0d", d), miss[d], !hit);
        check($sformatf("wstb%0d", d), wstb[d], exp_wstb);
        if (!hit) begin
            count_acks(d, 8, n);
            check($sformatf("miss_noack%0d", d), n, 0);
        end else begin
            for (int c = 1; c <= lat; c++) begin
                if (c == lat) begin
                    check($sformatf("ack%0d", d), ack[d], 1'b1);
                    check($sformatf("rd%0d", d), rd[d], exp_q.pop_front());
                end else begin
                    check($sformatf("ack_early%0d", d), ack[d], 1'b0);
                    tick();
                end
            end
            tick();
            check($sformatf("ack_drop%0d", d), ack[d], 1'b0);
            check($sformatf("rd_idle%0d", d), rd[d], 8'h00);
        end
        check($sformatf("reg_out%0d", d), reg_out[d], mdl_vec(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b1; we[d] = 1'b0; re[d] = 1'b0; addr[d] = '0; wd[d] = '0;
        end
        for (int j = 0; j < 8; j++) status[8*j +: 8] = 8'h7C + 8'(j);
        mdl_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_reg", reg_out[d], {16{8'hA5}});
            check("rst_ack", ack[d], 1'b0);
            check("rst_rd", rd[d], 8'h00);
            check("rst_wstb", wstb[d], 16'h0000);
            check("rst_miss", miss[d], 1'b0);
            check("rst_state", dbg[d], 2'd0);
        end
        rst_n = 1'b1;
        tick();

        // Write with no wait, then read with a 3-cycle wait
        do_txn(0, 1'b1, 1'b0, 32'h103, 8'h3C);
        check("t2_reg3", reg_out[0][31:24], 8'h3C);
        do_txn(1, 1'b0, 1'b1, 32'h112, 8'h00);

        // Misses and map edges
        do_txn(0, 1'b0, 1'b1, 32'h0FF, 8'h00);
        do_txn(1, 1'b0, 1'b1, 32'h118, 8'h00);
        do_txn(0, 1'b1, 1'b0, 32'h8000_0100, 8'h12);
        do_txn(0, 1'b0, 1'b1, 32'h117, 8'h00);
        do_txn(0, 1'b0, 1'b1, 32'h10F, 8'h00);
        do_txn(0, 1'b1, 1'b0, 32'h110, 8'hEE);
        do_txn(0, 1'b1, 1'b0, 32'h10F, 8'h0F);
        do_txn(0, 1'b0, 1'b1, 32'h103, 8'h00);

        // WE and RE together act as a write
        do_txn(0, 1'b1, 1'b1, 32'h105, 8'h5A);
        do_txn(1, 1'b1, 1'b1, 32'h100, 8'hC3);

        // Second write during WAIT is ignored
        strobe(1, 1'b1, 1'b0, 32'h101, 8'h11);
        check("t5_wstb1", wstb[1], 16'h0002);
        strobe(1, 1'b1, 1'b0, 32'h102, 8'h22);
        check("t5_wstb_ign", wstb[1], 16'h0000);
        mdl[1][1] = 8'h11;
        count_acks(1, 12, n);
        check("t5_single_ack", n, 1);
        check("t5_regs", reg_out[1], mdl_vec(1));

        // ACT dropped in WAIT: no ACK, committed write stays
        strobe(1, 1'b1, 1'b0, 32'h103, 8'h44);
        mdl[1][3] = 8'h44;
        act[1] = 1'b0;
        count_acks(1, 10, n);
        check("t5_abort_noack", n, 0);
        check("t5_abort_state", dbg[1], 2'd0);
        check("t5_abort_regs", reg_out[1], mdl_vec(1));
        act[1] = 1'b1;
        tick();
        do_txn(1, 1'b0, 1'b1, 32'h103, 8'h00);

        // Strobe with ACT low is ignored
        act[0] = 1'b0;
        strobe(0, 1'b1, 1'b0, 32'h104, 8'h99);
        check("t5_noact_wstb", wstb[0], 16'h0000);
        check("t5_noact_ack", ack[0], 1'b0);
        check("t5_noact_miss", miss[0], 1'b0);
        act[0] = 1'b1;
        tick();
        check("t5_noact_regs", reg_out[0], mdl_vec(0));

        // Random transactions, some unmapped
        for (int i = 0; i < 40; i++) begin
            int  d, off;
            bit  w, r;
            d   = $urandom_range(0, 1);
            off = $urandom_range(0, 27);
            w   = 1'($urandom_range(0, 1));
            r   = w ? 1'($urandom_range(0, 1)) : 1'b1;
            do_txn(d, w, r, BASE + 32'(off), 8'($urandom_range(0, 255)));
        end

        // Reset mid-transaction drops the ACK and restores REG_INIT
        strobe(1, 1'b0, 1'b1, 32'h101, 8'h00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mdl_reset();
        count_acks(1, 8, n);
        check("rst_mid_noack", n, 0);
        check("rst_mid_regs0", reg_out[0], mdl_vec(0));
        check("rst_mid_regs1", reg_out[1], mdl_vec(1));
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
